hazard_stall_unit: RTL

- Producer side of the operand-bypass path: decides when the front end must stall or flush so the forwarding unit only ever sees resolvable hazards.
- Sits beside the ID stage. Drives the PC write-enable, the IF/ID write-enable and flush, and the ID/EX bubble, hold and flush.
- Handles three cases: load-use stall (1 cycle), taken-branch flush (1 cycle) and multi-cycle MDU occupancy of EX (MDU_LATENCY cycles).

---
 rtl/hazard_stall_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Front-end stall/flush control beside ID: load-use stall, taken-branch flush, MDU EX occupancy.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1_IFID,
  input  logic [4:0]  RS2_IFID,
  input  logic        use_rs1_IFID,
  input  logic        use_rs2_IFID,
  input  logic [4:0]  RD_IDEX,
  input  logic        memRead_IDEX,
  input  logic        mdu_start_IDEX,
  input  logic        branch_taken_EX,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_hold,
  output logic        mdu_busy,
  output logic [15:0] stall_cycles
);

  localparam int unsigned PERF_W = 16;

  typedef enum logic {
    RUN,
    MDU_BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use_hit_c;

  // A load in EX whose nonzero destination feeds a source the ID instruction actually reads.
  assign load_use_hit_c = memRead_IDEX && (RD_IDEX != 5'd0) &&
                          ((use_rs1_IFID && (RS1_IFID == RD_IDEX)) ||
                           (use_rs2_IFID && (RS2_IFID == RD_IDEX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mealy decode; the MDU owns EX, so it outranks branch flush, which outranks load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    mdu_busy    = 1'b0;
    if (!rst) begin
      if ((state_q == MDU_BUSY) || mdu_start_IDEX) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_hold  = 1'b1;
        mdu_busy   = 1'b1;
        if (state_q == RUN) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_W'(MDU_LATENCY - 2);
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (branch_taken_EX) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use_hit_c) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;

  // Saturating count of edges on which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != '1)) begin
      stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = PERF_W'(0);
`endif

endmodule
